sr_mem: RTL and testbench
=========================

# sr_mem

Byte-addressable data memory for the schoolRISCV core, serving load/store instructions. Writes are synchronous with byte, halfword or word width. Reads are combinational, with zero- or sign-extension of byte and halfword loads to 32 bits. The block sits beside the datapath and is driven directly by the ALU result (address) and the rs2 value (store data).

## Interface
- `WORDS`, default 64: number of 32-bit words in the array; must be a power of two ≥ 2.
- `clk`  in  1: single clock; writes occur on the rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `data_addr`  in  32: byte address.
- `write_data`  in  32: store data; the low byte or halfword is used for narrow stores.
- `we`  in  1: write enable, sampled at the rising edge of `clk`.
- `sign`  in  1: 1 = sign-extend narrow loads; 0 = zero-extend.
- `byte_w`  in  1: byte access select.
- `half_w`  in  1: halfword access select.
- `word_w`  in  1: word access select.
- `read_data`  out  32: extended load result (combinational).

## Operation
- Storage is `WORDS` × 32-bit, little-endian.
  - Word index = `data_addr[log2(WORDS)+1:2]`.
  - Higher address bits are ignored, so addresses wrap modulo 4·`WORDS` bytes.
- Width selection priority: `byte_w` > `half_w` > `word_w`.
  - If none of the three is asserted, writes are suppressed and reads return the full word.
- Byte access: lane = `data_addr[1:0]`.
  - Write: `write_data[7:0]` goes into lane bits [8·lane+7 : 8·lane]; the other lanes are unchanged.
  - Read: selected byte in bits [7:0]; bits [31:8] = byte bit 7 when `sign`=1, else 0.
- Halfword access: `data_addr[1]` selects the low (0) or high (1) half; `data_addr[0]` is ignored.
  - Write: `write_data[15:0]` goes into the selected half; the other half is unchanged.
  - Read: bits [31:16] = half bit 15 when `sign`=1, else 0.
- Word access: `data_addr[1:0]` ignored; full 32-bit write and read. `sign` has no effect.
- Misaligned accesses do not trap. They are handled by truncating the low address bits as above.
- Reset: while `rst_n`=0, every word is cleared to 0 immediately (asynchronously), and writes are blocked.

## Timing
- Write: committed at the rising `clk` edge where `we`=1 and `rst_n`=1. It is visible on `read_data` immediately after that edge, provided the address is unchanged.
- Read: purely combinational from `data_addr`, `sign`, the width selects and the array contents. Zero-cycle latency.
- `read_data` after reset = 0 for every address and mode.
- Reset asserted mid-cycle: the array clears at once. An edge coinciding with `rst_n`=0 performs no write.
- Reset deassertion: the first write can occur at the first rising edge with `rst_n`=1.
- Simultaneous read and write of the same word: `read_data` shows the old contents until the edge, then the new contents.
- Inputs must be stable around the rising edge (standard setup/hold); there is no handshake.

## Test plan
- Word write, then read:
  - Release reset; word, `we`=1, addr 0x0, data 0x00000000, one clock.
  - Read word at 0x0 → `read_data` = 0x00000000.
- Signed byte:
  - Byte, `we`=1, addr 0x4, data 0x000000FE, one clock.
  - Byte read, `sign`=1 → 0xFFFFFFFE; `sign`=0 → 0x000000FE.
  - Word read at 0x4 → 0x000000FE.
- Byte lanes:
  - Word write 0x11223344 at 0x8.
  - Byte write 0xAA at 0xB → word read 0xAA223344.
  - Byte read at 0xA, unsigned → 0x00000022.
- Halfword:
  - Half write 0x8001 at 0xE over a word of 0.
  - Word read → 0x80010000.
  - Half read at 0xE signed → 0xFFFF8001; unsigned → 0x00008001; half read at 0xC → 0x00000000.
- `we`=0 and wrap:
  - A clock with `we`=0 leaves the contents unchanged.
  - A write to addr 4·`WORDS` aliases to word 0.
- Asynchronous reset:
  - Fill several words; pulse `rst_n` low between clock edges.
  - All reads return 0 immediately; a clock edge during reset with `we`=1 writes nothing.

Source files
------------

// File: rtl/sr_mem.sv
// -----------------------------------------------------------------------------
// sr_mem -- byte-addressable data memory for the schoolRISCV core.
//
// Stores WORDS x 32-bit little-endian words. Stores are synchronous and can be
// byte, halfword or word wide. Loads are combinational and narrow loads are
// zero- or sign-extended to 32 bits. Misaligned addresses are not trapped: the
// low address bits that do not apply to the selected width are ignored, and
// address bits above the array size are ignored, so addresses wrap.
//
// Ports:
//   clk         in   1   clock; writes commit on the rising edge
//   rst_n       in   1   asynchronous active-low reset; clears every word
//   data_addr   in  32   byte address
//   write_data  in  32   store data (low byte/halfword used for narrow stores)
//   we          in   1   write enable
//   sign        in   1   1 = sign-extend narrow loads, 0 = zero-extend
//   byte_w      in   1   byte access (highest priority)
//   half_w      in   1   halfword access
//   word_w      in   1   word access (lowest priority)
//   read_data   out 32   extended load result
// -----------------------------------------------------------------------------
module sr_mem #(
    parameter int WORDS = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] data_addr,
    input  logic [31:0] write_data,
    input  logic        we,
    input  logic        sign,
    input  logic        byte_w,
    input  logic        half_w,
    input  logic        word_w,
    output logic [31:0] read_data
);

    localparam int AW = $clog2(WORDS);

    logic [31:0]   mem_q [WORDS];
    logic [AW-1:0] word_idx;
    logic [1:0]    lane;
    logic          wr_en;
    logic [31:0]   wr_word_d;
    logic [31:0]   rd_word;
    logic [7:0]    rd_byte;
    logic [15:0]   rd_half;

    assign word_idx = data_addr[AW+1:2];
    assign lane     = data_addr[1:0];

    // Address bits above the array size are intentionally ignored (wrap).
    logic unused_addr_hi;
    assign unused_addr_hi = ^data_addr[31:AW+2];

    // With no width select asserted the store is suppressed.
    assign wr_en = we & (byte_w | half_w | word_w);

    // Merge the store data into the currently addressed word so only the
    // selected lanes change.
    always_comb begin
        wr_word_d = mem_q[word_idx];
        if (byte_w) begin
            wr_word_d[8*lane +: 8] = write_data[7:0];
        end else if (half_w) begin
            if (data_addr[1]) begin
                wr_word_d[31:16] = write_data[15:0];
            end else begin
                wr_word_d[15:0] = write_data[15:0];
            end
        end else if (word_w) begin
            wr_word_d = write_data;
        end
    end

    // One register per word so the whole array can clear asynchronously.
    generate
        for (genvar gi = 0; gi < WORDS; gi++) begin : g_word
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    mem_q[gi] <= 32'h0000_0000;
                end else if (wr_en && (word_idx == AW'(gi))) begin
                    mem_q[gi] <= wr_word_d;
                end
            end
        end
    endgenerate

    // Combinational load path with extension.
    assign rd_word = mem_q[word_idx];
    assign rd_byte = rd_word[8*lane +: 8];
    assign rd_half = data_addr[1] ? rd_word[31:16] : rd_word[15:0];

    always_comb begin
        read_data = rd_word;
        if (byte_w) begin
            read_data = {{24{sign & rd_byte[7]}}, rd_byte};
        end else if (half_w) begin
            read_data = {{16{sign & rd_half[15]}}, rd_half};
        end
    end

endmodule

// File: tb/tb_sr_mem.sv
// -----------------------------------------------------------------------------
// tb_sr_mem -- scoreboard bench for sr_mem.
//
// The driver issues loads/stores and pushes each load's expected value, taken
// from a byte-array reference model, into a queue. A separate monitor pops and
// compares on every falling clock edge where a load is presented.
// -----------------------------------------------------------------------------
module tb_sr_mem;

    localparam int WORDS  = 64;
    localparam int NBYTES = 4 * WORDS;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] data_addr = '0;
    logic [31:0] write_data = '0;
    logic        we = 1'b0;
    logic        sign = 1'b0;
    logic        byte_w = 1'b0;
    logic        half_w = 1'b0;
    logic        word_w = 1'b0;
    logic [31:0] read_data;

    sr_mem #(.WORDS(WORDS)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .data_addr  (data_addr),
        .write_data (write_data),
        .we         (we),
        .sign       (sign),
        .byte_w     (byte_w),
        .half_w     (half_w),
        .word_w     (word_w),
        .read_data  (read_data)
    );

    always #5 clk = ~clk;

    // Reference model: flat little-endian byte array.
    logic [7:0]  mem_m [NBYTES];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_q [$];
    string       name_q [$];
    logic        chk_valid = 1'b0;

    localparam logic [2:0] SEL_B = 3'b100;
    localparam logic [2:0] SEL_H = 3'b010;
    localparam logic [2:0] SEL_W = 3'b001;
    localparam logic [2:0] SEL_N = 3'b000;

    function automatic void model_clear();
        for (int i = 0; i < NBYTES; i++) mem_m[i] = 8'h00;
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a,
                                               input logic [2:0] sel,
                                               input logic sg);
        int          base;
        int          v;
        logic [31:0] r;
        base = int'(a % NBYTES);
        if (sel[2]) begin
            v = int'(mem_m[base]);
            if (sg && v >= 128) v = v - 256;
            r = 32'(v);
        end else if (sel[1]) begin
            base = base - (base % 2);
            v = int'(mem_m[base]) + 256 * int'(mem_m[base + 1]);
            if (sg && v >= 32768) v = v - 65536;
            r = 32'(v);
        end else begin
            base = base - (base % 4);
            r = {mem_m[base + 3], mem_m[base + 2], mem_m[base + 1], mem_m[base]};
        end
        return r;
    endfunction

    function automatic void model_write(input logic [31:0] a,
                                        input logic [31:0] d,
                                        input logic [2:0] sel);
        int base;
        base = int'(a % NBYTES);
        if (sel[2]) begin
            mem_m[base] = d[7:0];
        end else if (sel[1]) begin
            base = base - (base % 2);
            mem_m[base]     = d[7:0];
            mem_m[base + 1] = d[15:8];
        end else if (sel[0]) begin
            base = base - (base % 4);
            for (int k = 0; k < 4; k++) mem_m[base + k] = d[8*k +: 8];
        end
    endfunction

    task automatic drive(input logic [31:0] a, input logic [2:0] sel, input logic sg);
        data_addr = a;
        {byte_w, half_w, word_w} = sel;
        sign = sg;
    endtask

    // Store: one clock with we=1; model follows only if reset was released.
    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [2:0] sel);
        drive(a, sel, 1'b0);
        write_data = d;
        we = 1'b1;
        @(posedge clk);
        if (rst_n) model_write(a, d, sel);
        #1;
        we = 1'b0;
    endtask

    // A clock with we=0: nothing may change.
    task automatic idle_clk(input logic [31:0] a, input logic [31:0] d, input logic [2:0] sel);
        drive(a, sel, 1'b0);
        write_data = d;
        we = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // Load: expected value goes to the scoreboard; the monitor checks it.
    task automatic rd(input logic [31:0] a, input logic [2:0] sel, input logic sg,
                      input string name);
        drive(a, sel, sg);
        we = 1'b0;
        exp_q.push_back(rst_n ? model_read(a, sel, sg) : 32'h0);
        name_q.push_back(name);
        chk_valid = 1'b1;
        @(posedge clk);
        #1;
        chk_valid = 1'b0;
    endtask

    // Monitor: samples on the falling edge, away from the write edge.
    always @(negedge clk) begin
        if (chk_valid) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL scoreboard_underflow: read_data=%08h with no expected entry", read_data);
            end else begin
                logic [31:0] e;
                string       nm;
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                if (read_data !== e) begin
                    n_fail++;
                    $display("FAIL %s: addr=%08h read_data=%08h expected=%08h", nm, data_addr, read_data, e);
                end else begin
                    $display("load %s addr=%08h sel=%03b sign=%0d data=%08h ok", nm, data_addr,
                             {byte_w, half_w, word_w}, sign, read_data);
                end
            end
        end
    end

    initial begin
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        // In reset: everything reads zero.
        rd(32'h0, SEL_W, 1'b0, "reset_word");
        rd(32'h7, SEL_B, 1'b1, "reset_byte");
        rst_n = 1'b1;

        // Word write then read.
        wr(32'h0, 32'h0000_0000, SEL_W);
        rd(32'h0, SEL_W, 1'b0, "word_zero");

        // Signed byte.
        wr(32'h4, 32'h0000_00FE, SEL_B);
        rd(32'h4, SEL_B, 1'b1, "byte_signed");
        rd(32'h4, SEL_B, 1'b0, "byte_unsigned");
        rd(32'h4, SEL_W, 1'b0, "byte_as_word");

        // Byte lanes.
        wr(32'h8, 32'h1122_3344, SEL_W);
        wr(32'hB, 32'h5555_55AA, SEL_B);
        rd(32'h8, SEL_W, 1'b0, "lane3_word");
        rd(32'hA, SEL_B, 1'b0, "lane2_byte");

        // Halfword.
        wr(32'hE, 32'hDEAD_8001, SEL_H);
        rd(32'hC, SEL_W, 1'b0, "half_as_word");
        rd(32'hE, SEL_H, 1'b1, "half_signed");
        rd(32'hE, SEL_H, 1'b0, "half_unsigned");
        rd(32'hC, SEL_H, 1'b1, "half_low");
        rd(32'hF, SEL_H, 1'b0, "half_misaligned");

        // Priority and no-select.
        wr(32'h10, 32'hA5A5_A5A5, 3'b111);
        rd(32'h10, SEL_W, 1'b0, "prio_byte_wins");
        wr(32'h14, 32'h1234_5678, SEL_N);
        rd(32'h14, SEL_N, 1'b0, "no_select_write");

        // we=0 and wrap.
        idle_clk(32'h8, 32'hFFFF_FFFF, SEL_W);
        rd(32'h8, SEL_W, 1'b0, "we0_unchanged");
        wr(32'(NBYTES), 32'hCAFE_BABE, SEL_W);
        rd(32'h0, SEL_W, 1'b0, "wrap_alias");

        // Randomized mix.
        for (int i = 0; i < 300; i++) begin
            logic [31:0] a;
            logic [2:0]  sel;
            int          op;
            a   = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, NBYTES - 1));
            sel = 3'($urandom_range(0, 7));
            op  = $urandom_range(0, 2);
            if (op == 0)      wr(a, $urandom, sel);
            else if (op == 1) rd(a, sel, 1'($urandom_range(0, 1)), "random");
            else              idle_clk(a, $urandom, sel);
        end

        // Asynchronous reset between edges.
        for (int k = 0; k < 8; k++) wr(32'(k * 4), 32'hF00D_0000 + 32'(k), SEL_W);
        #2;
        rst_n = 1'b0;
        model_clear();
        rd(32'h4, SEL_W, 1'b0, "reset_immediate");
        wr(32'h8, 32'hBEEF_BEEF, SEL_W);
        rd(32'h8, SEL_W, 1'b0, "reset_blocks_write");
        rst_n = 1'b1;
        rd(32'h8, SEL_W, 1'b0, "after_reset");
        rd(32'h1C, SEL_H, 1'b1, "after_reset_half");
        wr(32'h8, 32'h0BAD_F00D, SEL_W);
        rd(32'h8, SEL_W, 1'b0, "first_write_after_reset");

        repeat (3) @(posedge clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
